// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin grant arbiter: FSM state encoding and
// default configuration values.
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int DEFAULT_W        = 4;
  localparam int DEFAULT_MAX_HOLD = 8;

endpackage

// File: rtl/grant_decoder.sv
// Combinational W-to-2**W one-hot decoder with enable; output is all zero
// when the enable is low.
module grant_decoder #(
  parameter int W = 4
) (
  input  logic [W-1:0]    idx,
  input  logic            en,
  output logic [2**W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered grant index and decoded one-hot grant.
// Optional forced release after MAX_HOLD cycles is compiled in by ARB_TIMEOUT_EN.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int W        = DEFAULT_W,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2**W-1:0] req,
  output logic [2**W-1:0] gnt,
  output logic [W-1:0]    gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  localparam int N = 2**W;

  // First set request searching upward from ptr+1, wrapping modulo N; the
  // last candidate examined is ptr itself.
  function automatic logic [W-1:0] rr_pick(input logic [N-1:0] r,
                                           input logic [W-1:0] ptr);
    logic [W-1:0] cand;
    logic         found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = ptr + W'(i);
      if (!found && r[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

  arb_state_e   state_q, state_d;
  logic [W-1:0] gnt_idx_q, gnt_idx_d;
  logic [W-1:0] last_ptr_q, last_ptr_d;
  logic         gnt_valid_q, gnt_valid_d;
  logic         timeout_q, timeout_d;
  logic [W-1:0] pick;

  assign pick = rr_pick(req, last_ptr_q);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    last_ptr_d  = last_ptr_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d      = hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_idx_d   = pick;
          last_ptr_d  = pick;
          gnt_valid_d = 1'b1;
          state_d     = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d      = 8'd0;
`endif
        end else begin
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!req[gnt_idx_q]) begin
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          state_d     = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_q == 8'(MAX_HOLD - 1)) begin
          // last_ptr already points at this owner, so it is not favoured next
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          timeout_d   = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          hold_d      = hold_q + 8'd1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_idx_q   <= '0;
      last_ptr_q  <= '1;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      last_ptr_q  <= last_ptr_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= hold_d;
`endif
    end
  end

`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD != 0) & timeout_q;
  assign timeout = 1'b0;
`endif

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

  grant_decoder #(.W(W)) u_grant_decoder (
    .idx    (gnt_idx_q),
    .en     (gnt_valid_q),
    .onehot (gnt)
  );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed scoreboard bench for rr_grant_arbiter (W=4, MAX_HOLD=8); the
// timeout sequence follows ARB_TIMEOUT_EN.
module tb_rr_grant_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        vld;
    logic        to;
    string       tag;
  } exp_t;

  exp_t sb[$];

  rr_grant_arbiter #(.W(4), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_out(input exp_t e);
    tests++;
    assert (gnt === e.gnt) else begin
      errors++;
      $error("FAIL %s gnt: got %h want %h", e.tag, gnt, e.gnt);
    end
    tests++;
    assert (gnt_valid === e.vld) else begin
      errors++;
      $error("FAIL %s gnt_valid: got %b want %b", e.tag, gnt_valid, e.vld);
    end
    tests++;
    assert (timeout === e.to) else begin
      errors++;
      $error("FAIL %s timeout: got %b want %b", e.tag, timeout, e.to);
    end
    if (e.vld) begin
      tests++;
      assert (gnt_idx === e.idx) else begin
        errors++;
        $error("FAIL %s gnt_idx: got %0d want %0d", e.tag, gnt_idx, e.idx);
      end
    end
  endtask

  // Drive req for one cycle, queue the expected post-edge outputs, then
  // compare after the edge.
  task automatic cyc(input logic [15:0] r, input logic [15:0] eg,
                     input logic [3:0] ei, input logic ev, input logic et,
                     input string tag);
    exp_t e;
    req   = r;
    e.gnt = eg;
    e.idx = ei;
    e.vld = ev;
    e.to  = et;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++;
      errors++;
      $error("FAIL %s scoreboard: got empty want entry", tag);
    end else begin
      check_out(sb.pop_front());
    end
  endtask

  task automatic do_reset();
    req = 16'h0000;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    exp_t z;
    rst = 1'b1;
    req = 16'hFFFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    z.gnt = 16'h0000; z.idx = 4'd0; z.vld = 1'b0; z.to = 1'b0; z.tag = "reset";
    check_out(z);
    tests++;
    assert (gnt_idx === 4'd0) else begin
      errors++;
      $error("FAIL reset gnt_idx: got %0d want 0", gnt_idx);
    end
    rst = 1'b0;

    cyc(16'hFFFF, 16'h0001, 4'd0, 1'b1, 1'b0, "first_grant");
    cyc(16'hFFFF, 16'h0001, 4'd0, 1'b1, 1'b0, "no_preempt");
    cyc(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, "release0");
    cyc(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, "idle_stay");

    // Asynchronous reset in the middle of a grant
    cyc(16'h0020, 16'h0020, 4'd5, 1'b1, 1'b0, "grant5");
    cyc(16'h0020, 16'h0020, 4'd5, 1'b1, 1'b0, "hold5");
    #2 rst = 1'b1;
    #1;
    tests++;
    assert (gnt === 16'h0000) else begin
      errors++;
      $error("FAIL async_rst gnt: got %h want 0000", gnt);
    end
    tests++;
    assert (gnt_valid === 1'b0) else begin
      errors++;
      $error("FAIL async_rst gnt_valid: got %b want 0", gnt_valid);
    end
    #1 rst = 1'b0;
    cyc(16'h0041, 16'h0001, 4'd0, 1'b1, 1'b0, "post_rst_favour0");
    cyc(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, "post_rst_rel");

    // Rotation 0 -> 4 -> 8 -> 0
    do_reset();
    cyc(16'h0111, 16'h0001, 4'd0, 1'b1, 1'b0, "rot_g0");
    cyc(16'h0111, 16'h0001, 4'd0, 1'b1, 1'b0, "rot_h0");
    cyc(16'h0110, 16'h0000, 4'd0, 1'b0, 1'b0, "rot_r0");
    cyc(16'h0111, 16'h0010, 4'd4, 1'b1, 1'b0, "rot_g4");
    cyc(16'h0111, 16'h0010, 4'd4, 1'b1, 1'b0, "rot_h4");
    cyc(16'h0101, 16'h0000, 4'd0, 1'b0, 1'b0, "rot_r4");
    cyc(16'h0111, 16'h0100, 4'd8, 1'b1, 1'b0, "rot_g8");
    cyc(16'h0111, 16'h0100, 4'd8, 1'b1, 1'b0, "rot_h8");
    cyc(16'h0011, 16'h0000, 4'd0, 1'b0, 1'b0, "rot_r8");
    cyc(16'h0111, 16'h0001, 4'd0, 1'b1, 1'b0, "rot_g0b");
    cyc(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, "rot_end");

    // Wrap from index 15 to index 1
    cyc(16'h8000, 16'h8000, 4'd15, 1'b1, 1'b0, "wrap_g15");
    cyc(16'h8002, 16'h8000, 4'd15, 1'b1, 1'b0, "wrap_h15");
    cyc(16'h0002, 16'h0000, 4'd0,  1'b0, 1'b0, "wrap_r15");
    cyc(16'h8002, 16'h0002, 4'd1,  1'b1, 1'b0, "wrap_g1");
    cyc(16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0, "wrap_end");

    // Late arrival waits for the current owner
    cyc(16'h0004, 16'h0004, 4'd2, 1'b1, 1'b0, "late_g2");
    cyc(16'h0204, 16'h0004, 4'd2, 1'b1, 1'b0, "late_h2a");
    cyc(16'h0204, 16'h0004, 4'd2, 1'b1, 1'b0, "late_h2b");
    cyc(16'h0200, 16'h0000, 4'd0, 1'b0, 1'b0, "late_r2");
    cyc(16'h0200, 16'h0200, 4'd9, 1'b1, 1'b0, "late_g9");
    cyc(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, "late_end");

    // Sole requester is re-granted after a one-cycle bubble
    cyc(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, "solo_idle");
    cyc(16'h0008, 16'h0008, 4'd3, 1'b1, 1'b0, "solo_g3");
    cyc(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, "solo_r3");
    cyc(16'h0008, 16'h0008, 4'd3, 1'b1, 1'b0, "solo_g3b");
    cyc(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, "solo_end");

    do_reset();
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++)
      cyc(16'h0003, 16'h0001, 4'd0, 1'b1, 1'b0, "to_own0");
    cyc(16'h0003, 16'h0000, 4'd0, 1'b0, 1'b1, "to_pulse0");
    cyc(16'h0003, 16'h0002, 4'd1, 1'b1, 1'b0, "to_g1");
    for (int i = 0; i < 7; i++)
      cyc(16'h0003, 16'h0002, 4'd1, 1'b1, 1'b0, "to_own1");
    cyc(16'h0001, 16'h0000, 4'd0, 1'b0, 1'b0, "to_drop_same_cycle");
    cyc(16'h0001, 16'h0001, 4'd0, 1'b1, 1'b0, "to_g0b");
    cyc(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, "to_end");
`else
    for (int i = 0; i < 12; i++)
      cyc(16'h0003, 16'h0001, 4'd0, 1'b1, 1'b0, "nohold_limit");
    cyc(16'h0002, 16'h0000, 4'd0, 1'b0, 1'b0, "nohold_rel");
    cyc(16'h0003, 16'h0002, 4'd1, 1'b1, 1'b0, "nohold_g1");
    cyc(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, "nohold_end");
`endif

    if (sb.size() != 0) begin
      tests++;
      errors++;
      $error("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Round-robin arbiter sharing one resource between up to 16 requesters. A registered grant index drives an internal 4-to-16 one-hot decoder to produce the per-requester grant lines. It sits in front of any shared datapath slot whose select is a binary index expanded by a decoder, and it sequences ownership of that slot.

## Interface
- `W`, default 4: index width; requester count `N = 2**W`; legal range 2..4.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per owner; only used with `ARB_TIMEOUT_EN`; legal range 2..255.
- `clk`, input, 1 bit: single clock; all state is updated on the rising edge.
- `rst`, input, 1 bit: reset, asynchronous and active-high.
- `req`, input, `N` bits: request lines; a requester holds its bit high for as long as it wants ownership.
- `gnt`, output, `N` bits: registered one-hot grant; all zero when there is no owner.
- `gnt_idx`, output, `W` bits: binary index of the current owner; valid only while `gnt_valid` is high.
- `gnt_valid`, output, 1 bit: high while an owner holds the grant.
- `timeout`, output, 1 bit: one-cycle pulse when a grant is force-released.

## Operation
- Reset values:
  - `gnt = 0`, `gnt_idx = 0`, `gnt_valid = 0`, `timeout = 0`.
  - Internal `last_ptr = N-1`, so the first arbitration after reset favours index 0.
  - State is `IDLE`.
- Two-state FSM, `IDLE` and `GRANT`.
- `IDLE`:
  - If `req != 0`, select the first set bit searching upward from `last_ptr+1`, wrapping modulo `N`.
  - Register the selection into `gnt_idx` and `last_ptr`, set `gnt_valid`, and move to `GRANT`.
  - If `req == 0`, stay in `IDLE` with all outputs at 0.
- `GRANT`:
  - Hold `gnt_idx` while `req[gnt_idx]` is 1.
  - When `req[gnt_idx]` is 0, clear `gnt_valid` and `gnt`, and move to `IDLE`.
  - Other request bits are ignored while in `GRANT`; there is no preemption.
- `gnt` is always `decode(gnt_idx)` gated by `gnt_valid`. It is never multi-hot.
- Requests from other requesters that arrive during `GRANT` wait and are considered at the next `IDLE` cycle.
- Wrap-around: with `last_ptr = N-1`, the search starts at 0.
- A requester that is the only one asserting is re-granted after each release, one `IDLE` cycle later.
- Reset mid-grant: outputs clear asynchronously and the FSM returns to `IDLE` with `last_ptr = N-1`.

## Timing
- Grant latency: `req` rises in cycle N with the FSM in `IDLE` → `gnt` and `gnt_valid` are high from cycle N+1.
- Release latency: `req[gnt_idx]` falls in cycle M → `gnt` is 0 in cycle M+1. That cycle is the mandatory `IDLE` bubble.
- Back-to-back ownership: the next grant is earliest at cycle M+2. Worst-case wait for a continuously asserted requester is `N-1` ownership periods.
- Timeout (`ARB_TIMEOUT_EN` only):
  - The hold counter is 0 at grant and increments each `GRANT` cycle.
  - At the `GRANT` cycle where the counter equals `MAX_HOLD-1` and the request is still high, the FSM moves to `IDLE`.
  - At the next edge, `gnt` clears and `timeout` pulses for exactly one cycle.
  - If the request drops in that same cycle, normal release applies and `timeout` does not pulse.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - The hold counter and forced release are compiled in.
  - A timed-out requester is not favoured: `last_ptr` already equals its index, so the next search starts past it.
- `ARB_TIMEOUT_EN` undefined:
  - No counter logic.
  - `timeout` is tied to 0.
  - Ownership lasts until the request drops; `MAX_HOLD` is ignored.

## Structure
- Shared package `arb_pkg` holds:
  - the state encoding constants `ST_IDLE = 1'b0` and `ST_GRANT = 1'b1`;
  - the default `W` and `MAX_HOLD` values.
- One sub-module, `grant_decoder`: a combinational `W`-to-`N` one-hot decoder with an enable input, instantiated once to form `gnt`.
- The round-robin search is a function inside `rr_grant_arbiter`.

## Test plan
- Reset check: assert `rst` with `req = 16'hFFFF` → all outputs 0. Release reset → cycle 1 has `gnt_idx = 0` and `gnt = 16'h0001`.
- Rotation: hold `req = 16'h0111` and drop each owner's bit for one cycle after a 2-cycle hold → grants go 0, 4, 8, 0 in order.
- Wrap: grant index 15 with `req = 16'h8002`, then drop bit 15 → next `gnt_idx = 1` at M+2.
- Late arrival: `req = 16'h0004` granted, then `req[9]` rises during `GRANT` → `gnt` stays `16'h0004` until bit 2 drops; index 9 is granted two cycles later.
- Async reset mid-grant: pulse `rst` between clock edges while `gnt = 16'h0020` → `gnt` is 0 immediately, and the next grant after reset favours index 0.
- Timeout (`ARB_TIMEOUT_EN`, `MAX_HOLD = 8`): hold `req = 16'h0003` continuously → index 0 owns for 8 cycles, then `timeout` pulses once and index 1 is granted at the following cycle.
